fetch_queue_unit: RTL and testbench
===================================

Name: fetch_queue_unit

Overview:
- Parametrised instruction-fetch front end for the pipelined RISC-V core.
- Issues sequential PC requests to a handshaked instruction memory and tolerates variable memory latency with several requests in flight.
- Buffers returned instructions in a prefetch queue feeding decode over a valid/ready interface.
- On a branch/jump redirect, drops stale in-flight responses and restarts fetch at the redirect target.

Parameters:
- XLEN, 32, PC/address width.
- ILEN, 32, instruction width.
- QDEPTH, 4, prefetch queue entries (power of two, >=2).
- MAX_OUT, 2, maximum outstanding IMEM requests (>=1, <=QDEPTH).
- RESET_PC, 0, PC after reset.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- redirect_valid  in  1  branch taken / flush request (from MEM-stage branch resolution)
- redirect_pc  in  XLEN  redirect target
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  IMEM accepts request
- imem_req_addr  out  XLEN  fetch address
- imem_rsp_valid  in  1  instruction returned, strictly in request order
- imem_rsp_data  in  ILEN  returned instruction
- dec_valid  out  1  instruction available to decode
- dec_ready  in  1  decode accepts (deasserted = stall)
- dec_instr  out  ILEN  instruction to decode
- dec_pc  out  XLEN  PC of dec_instr

Behaviour:
- Reset: clk and rst as already decided — reset rst, asynchronous, active-high; clock clk.
  - While rst is high: fetch PC = RESET_PC; queue, outstanding count and drop count = 0; imem_req_valid = 0; dec_valid = 0; dec_instr = 0; dec_pc = 0.
  - Reset mid-transfer discards everything. Responses arriving while rst is high are ignored.
- Request issue:
  - imem_req_valid = !rst && !redirect_valid && outstanding < MAX_OUT && (queue_count + outstanding) < QDEPTH.
  - The credit rule guarantees no queue overflow.
  - imem_req_addr = fetch PC.
  - On accept (valid && ready): fetch PC += 4 (mod 2^XLEN; 0xFFFFFFFC wraps to 0), the PC is pushed into the in-flight PC FIFO, and outstanding is incremented.
- Response:
  - Each imem_rsp_valid pops the in-flight PC FIFO and decrements outstanding.
  - If drop_cnt > 0: discard the response and decrement drop_cnt.
  - Otherwise push {pc, instr} into the prefetch queue.
  - A request accepted in the same cycle as a response nets outstanding unchanged.
- Decode side:
  - dec_valid = queue non-empty && !redirect_valid.
  - dec_instr/dec_pc come from the queue head.
  - Pop on dec_valid && dec_ready. Queue head is held stable while dec_ready = 0.
  - No bypass: a response pushed into an empty queue appears on dec_* the next cycle. Minimum fetch-to-decode latency is IMEM latency + 1.
  - Simultaneous push and pop: count unchanged.
- Redirect (single-cycle pulse, priority over everything):
  - Fetch PC <= {redirect_pc[XLEN-1:2], 2'b00}.
  - Prefetch queue is cleared.
  - drop_cnt <= outstanding − (imem_rsp_valid ? 1 : 0). A response arriving in the redirect cycle is itself discarded.
  - No request is issued and no pop occurs in the redirect cycle.
  - The first request to the new PC is issued the next cycle.
- Back-to-back redirects: the last one wins; drop accounting is cumulative via outstanding.
- Boundary conditions:
  - Queue full: imem_req_valid stays low via credit.
  - imem_req_ready low: address and valid are held stable until accepted, unless a redirect intervenes.
  - A response with outstanding = 0 is a protocol error and is ignored. Verification asserts it never occurs.

Decomposition:
- Package fetch_pkg holds:
  - XLEN, ILEN, PC_STEP = 4
  - NOP encoding 32'h00000013
  - fetch_entry_t {pc, instr}
- Sub-module fetch_fifo: generic synchronous FIFO with parameters WIDTH and DEPTH, async reset and a clear input.
  - Instantiated twice: in-flight PC FIFO (depth MAX_OUT) and prefetch queue (depth QDEPTH).

Test Plan:
- Reset release, IMEM 1-cycle latency, dec_ready = 1 → requests at 0x0, 0x4, 0x8…; dec_pc 0x0 appears 2 cycles after the first accept, then one instruction per cycle.
- dec_ready = 0 for 10 cycles → exactly QDEPTH = 4 instructions are buffered, imem_req_valid drops, and the head stays at the same PC. On release, PCs drain in order with no gaps or duplicates.
- Redirect to 0x100 with 2 requests outstanding (3-cycle IMEM) → both stale responses are discarded; the next dec_pc is 0x100 with the correct instruction.
- Redirect coinciding with imem_rsp_valid, and a redirect to 0x102 → the response is discarded and fetch restarts at 0x100.
- imem_req_ready toggled randomly → imem_req_addr is stable while pending and the PC sequence is strictly +4.
- Fetch PC 0xFFFFFFF8 → next requests are 0xFFFFFFFC then 0x0. Assert rst mid-stream → dec_valid = 0 immediately and fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// ============================================================================
//  Module      : fetch_pkg
//  Description : Shared constants and types for the instruction-fetch front end
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fetch_pkg;

   localparam int          XLEN      = 32;
   localparam int          ILEN      = 32;
   localparam int          PC_STEP   = 4;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [ILEN-1:0] instr;
   } fetch_entry_t;

endpackage

`default_nettype wire

// File: rtl/fetch_fifo.sv
// ============================================================================
//  Module      : fetch_fifo
//  Description : Synchronous FIFO with occupancy count and synchronous clear
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_fifo
   import fetch_pkg::*;
#(
   parameter  int WIDTH = 8,
   parameter  int DEPTH = 4,
   localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] data_o,
   output logic [CW-1:0]    count_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             w_push;
   logic             w_pop;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign w_push = push_i && (count_q != CW'(DEPTH));
   assign w_pop  = pop_i && (count_q != '0);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (clear_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (w_push) wr_ptr_d = ptr_inc(wr_ptr_q);
         if (w_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
         case ({w_push, w_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage is not reset; consumers qualify data_o with count_o
   always_ff @(posedge clk) begin
      if (w_push && !clear_i) mem_q[wr_ptr_q] <= data_i;
   end

   assign data_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/fetch_queue_unit.sv
// ============================================================================
//  Module      : fetch_queue_unit
//  Description : Sequential instruction fetch with in-flight tracking,
//                prefetch queue and redirect flush
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_queue_unit #(
   parameter int              XLEN     = fetch_pkg::XLEN,
   parameter int              ILEN     = fetch_pkg::ILEN,
   parameter int              QDEPTH   = 4,
   parameter int              MAX_OUT  = 2,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_rsp_valid,
   input  logic [ILEN-1:0] imem_rsp_data,
   output logic            dec_valid,
   input  logic            dec_ready,
   output logic [ILEN-1:0] dec_instr,
   output logic [XLEN-1:0] dec_pc
);

   import fetch_pkg::*;

   localparam int OW = $clog2(MAX_OUT + 1);
   localparam int QW = $clog2(QDEPTH + 1);

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [ILEN-1:0] instr;
   } entry_t;

   logic [XLEN-1:0] pc_q, pc_d;
   logic [OW-1:0]   drop_q, drop_d;

   logic [OW-1:0]   w_out_cnt;
   logic [QW-1:0]   w_q_cnt;
   logic [XLEN-1:0] w_rsp_pc;
   entry_t          w_q_wdata;
   entry_t          w_q_head;
   logic            w_req_fire;
   logic            w_rsp_fire;
   logic            w_q_push;
   logic            w_q_pop;
   logic            w_q_nonempty;
   logic            w_unused;

   // Outstanding credit also reserves queue slots, so the queue cannot overflow
   assign imem_req_valid = !rst && !redirect_valid
                        && (int'(w_out_cnt) < MAX_OUT)
                        && ((int'(w_q_cnt) + int'(w_out_cnt)) < QDEPTH);
   assign imem_req_addr  = pc_q;
   assign w_req_fire     = imem_req_valid && imem_req_ready;

   // A response with nothing in flight is a protocol error and is ignored
   assign w_rsp_fire = imem_rsp_valid && (w_out_cnt != '0);
   assign w_q_push   = w_rsp_fire && !redirect_valid && (drop_q == '0);
   assign w_q_wdata  = '{pc: w_rsp_pc, instr: imem_rsp_data};

   assign w_q_nonempty = (w_q_cnt != '0);
   assign dec_valid    = w_q_nonempty && !redirect_valid;
   assign w_q_pop      = dec_valid && dec_ready;
   assign dec_instr    = w_q_nonempty ? w_q_head.instr : '0;
   assign dec_pc       = w_q_nonempty ? w_q_head.pc    : '0;

   assign w_unused = ^redirect_pc[1:0];

   always_comb begin
      pc_d   = pc_q;
      drop_d = drop_q;
      if (redirect_valid) begin
         pc_d   = {redirect_pc[XLEN-1:2], 2'b00};
         drop_d = w_out_cnt - OW'(w_rsp_fire);
      end else begin
         if (w_req_fire) pc_d = pc_q + XLEN'(PC_STEP);
         if (w_rsp_fire && (drop_q != '0)) drop_d = drop_q - OW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q   <= RESET_PC;
         drop_q <= '0;
      end else begin
         pc_q   <= pc_d;
         drop_q <= drop_d;
      end
   end

   fetch_fifo #(
      .WIDTH (XLEN),
      .DEPTH (MAX_OUT)
   ) u_inflight (
      .clk     (clk),
      .rst     (rst),
      .clear_i (1'b0),
      .push_i  (w_req_fire),
      .data_i  (pc_q),
      .pop_i   (w_rsp_fire),
      .data_o  (w_rsp_pc),
      .count_o (w_out_cnt)
   );

   fetch_fifo #(
      .WIDTH ($bits(entry_t)),
      .DEPTH (QDEPTH)
   ) u_prefetch (
      .clk     (clk),
      .rst     (rst),
      .clear_i (redirect_valid),
      .push_i  (w_q_push),
      .data_i  (w_q_wdata),
      .pop_i   (w_q_pop),
      .data_o  (w_q_head),
      .count_o (w_q_cnt)
   );

endmodule

`default_nettype wire

// File: tb/tb_fetch_queue_unit.sv
// ============================================================================
//  Module      : tb_fetch_queue_unit
//  Description : Self-checking bench for fetch_queue_unit with an IMEM model
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_queue_unit;
   import fetch_pkg::*;

   localparam int QD = 4;
   localparam int MO = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        dec_valid;
   logic        dec_ready;
   logic [31:0] dec_instr;
   logic [31:0] dec_pc;

   always #5 clk = ~clk;

   fetch_queue_unit #(
      .XLEN     (32),
      .ILEN     (32),
      .QDEPTH   (QD),
      .MAX_OUT  (MO),
      .RESET_PC (32'h0)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .dec_valid      (dec_valid),
      .dec_ready      (dec_ready),
      .dec_instr      (dec_instr),
      .dec_pc         (dec_pc)
   );

   typedef struct {
      logic [31:0] addr;
      int          due;
      int          ep;
   } pend_t;

   pend_t        pend[$];
   int           n_assert = 0;
   int           n_fail   = 0;
   int           cyc, lat, last_due, epoch, out_m, occ_m, ndec;
   int           first_acc, first_dec;
   logic [31:0]  exp_req, exp_dec, prev_addr, tgt_watch;
   bit           prev_pend, wrap_seen, seen_tgt;
   fetch_entry_t last_dec;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[7:0], a[31:8]} ^ 32'h5A5A_1234;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_assert++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   // One clock cycle: drive IMEM response, check outputs, advance the model
   task automatic cycle();
      pend_t r;
      bit    rf, df;
      int    due;
      if (pend.size() > 0 && pend[0].due <= cyc) begin
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = mem_word(pend[0].addr);
      end else begin
         imem_rsp_valid = 1'b0;
         imem_rsp_data  = $urandom;
      end
      #1;
      if (prev_pend && !redirect_valid) begin
         chk("req_hold_valid", 32'(imem_req_valid), 32'd1);
         chk("req_hold_addr", imem_req_addr, prev_addr);
      end
      if (redirect_valid) begin
         chk("req_valid_in_redirect", 32'(imem_req_valid), 32'd0);
         chk("dec_valid_in_redirect", 32'(dec_valid), 32'd0);
      end else if (dec_valid) begin
         chk("dec_pc", dec_pc, exp_dec);
         chk("dec_instr", dec_instr, mem_word(exp_dec));
         if (first_dec < 0) first_dec = cyc;
      end
      rf = imem_req_valid && imem_req_ready;
      df = dec_valid && dec_ready && !redirect_valid;
      if (imem_rsp_valid) begin
         r = pend.pop_front();
         out_m--;
         if (r.ep == epoch && !redirect_valid) occ_m++;
      end
      if (redirect_valid) begin
         epoch++;
         exp_req = redirect_pc & ~32'h3;
         exp_dec = redirect_pc & ~32'h3;
         occ_m   = 0;
      end
      if (rf) begin
         chk("req_addr", imem_req_addr, exp_req);
         due = (cyc + lat > last_due) ? cyc + lat : last_due + 1;
         pend.push_back('{imem_req_addr, due, epoch});
         last_due = due;
         exp_req  = exp_req + 32'd4;
         out_m++;
         if (first_acc < 0) first_acc = cyc;
      end
      if (df) begin
         if (exp_dec == 32'h0 && ndec > 0 && last_dec.pc == 32'hFFFF_FFFC) wrap_seen = 1'b1;
         if (exp_dec == tgt_watch) seen_tgt = 1'b1;
         last_dec = '{pc: exp_dec, instr: dec_instr};
         exp_dec  = exp_dec + 32'd4;
         occ_m--;
         ndec++;
      end
      chk("outstanding_bound", 32'(out_m <= MO), 32'd1);
      chk("queue_bound", 32'(occ_m <= QD), 32'd1);
      prev_pend = imem_req_valid && !imem_req_ready;
      prev_addr = imem_req_addr;
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic model_reset();
      pend.delete();
      out_m     = 0;
      occ_m     = 0;
      epoch++;
      last_due  = -1;
      prev_pend = 1'b0;
      exp_req   = 32'h0;
      exp_dec   = 32'h0;
      cyc       = 0;
      first_acc = -1;
      first_dec = -1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached before end of test");
      $fatal(1, "watchdog timeout");
   end

   initial begin
      int nd0;
      rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
      imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0; dec_ready = 1'b0;
      epoch = 0; ndec = 0; lat = 1; tgt_watch = 32'hFFFF_FFFF; wrap_seen = 0; seen_tgt = 0;
      last_dec = '{pc: 32'h1, instr: 32'h0};
      model_reset();

      // Reset state, with a stray response that must be ignored
      repeat (3) @(posedge clk);
      #1;
      imem_rsp_valid = 1'b1; imem_rsp_data = 32'h1234_5678; imem_req_ready = 1'b1;
      #1;
      chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
      chk("rst_dec_valid", 32'(dec_valid), 32'd0);
      chk("rst_dec_pc", dec_pc, 32'h0);
      chk("rst_dec_instr", dec_instr, 32'h0);
      chk("rst_req_addr", imem_req_addr, 32'h0);
      imem_rsp_valid = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Streaming, 1-cycle IMEM
      dec_ready = 1'b1; lat = 1;
      repeat (20) cycle();
      chk("first_accept_cycle", 32'(first_acc), 32'd0);
      chk("fetch_to_decode_latency", 32'(first_dec - first_acc), 32'd2);
      chk("throughput", 32'(ndec), 32'd18);

      // Decode stall fills the queue
      dec_ready = 1'b0;
      repeat (10) cycle();
      #1;
      chk("stall_req_valid", 32'(imem_req_valid), 32'd0);
      chk("stall_dec_valid", 32'(dec_valid), 32'd1);
      chk("stall_head_pc", dec_pc, exp_dec);
      chk("stall_buffered", 32'(occ_m), 32'(QD));
      chk("stall_outstanding", 32'(out_m), 32'd0);
      dec_ready = 1'b1;
      repeat (12) cycle();

      // Redirect with two requests in flight on a 3-cycle IMEM
      lat = 3;
      for (int k = 0; k < 20 && out_m != 2; k++) cycle();
      chk("two_outstanding", 32'(out_m), 32'd2);
      redirect_valid = 1'b1; redirect_pc = 32'h100; tgt_watch = 32'h100; seen_tgt = 0;
      cycle();
      redirect_valid = 1'b0;
      repeat (15) cycle();
      chk("redirect_target_seen", 32'(seen_tgt), 32'd1);

      // Redirect landing on a response cycle, misaligned target
      for (int k = 0; k < 20 && !(pend.size() > 0 && pend[0].due <= cyc); k++) cycle();
      chk("rsp_ready_for_redirect", 32'(pend.size() > 0 && pend[0].due <= cyc), 32'd1);
      redirect_valid = 1'b1; redirect_pc = 32'h102; tgt_watch = 32'h100; seen_tgt = 0;
      cycle();
      redirect_valid = 1'b0;
      repeat (15) cycle();
      chk("redirect_misaligned_seen", 32'(seen_tgt), 32'd1);

      // Randomized handshakes, latencies and redirects
      nd0 = ndec;
      for (int k = 0; k < 300; k++) begin
         imem_req_ready = 1'($urandom_range(0, 1));
         dec_ready      = ($urandom_range(0, 3) != 0);
         lat            = $urandom_range(1, 4);
         if ($urandom_range(0, 29) == 0) begin
            redirect_valid = 1'b1;
            redirect_pc    = $urandom;
         end else begin
            redirect_valid = 1'b0;
         end
         cycle();
      end
      redirect_valid = 1'b0;
      chk("random_progress", 32'((ndec - nd0) >= 30), 32'd1);

      // Address wrap
      imem_req_ready = 1'b1; dec_ready = 1'b1; lat = 1; wrap_seen = 0;
      redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8;
      cycle();
      redirect_valid = 1'b0;
      repeat (12) cycle();
      chk("pc_wrap_seen", 32'(wrap_seen), 32'd1);

      // Reset asserted mid-stream
      chk("pre_reset_dec_valid", 32'(dec_valid), 32'd1);
      rst = 1'b1;
      #1;
      chk("async_rst_dec_valid", 32'(dec_valid), 32'd0);
      chk("async_rst_req_valid", 32'(imem_req_valid), 32'd0);
      chk("async_rst_dec_pc", dec_pc, 32'h0);
      chk("async_rst_dec_instr", dec_instr, 32'h0);
      model_reset();
      @(posedge clk);
      #1;
      imem_rsp_valid = 1'b1; imem_rsp_data = $urandom;
      @(posedge clk);
      #1;
      chk("rst_hold_dec_valid", 32'(dec_valid), 32'd0);
      imem_rsp_valid = 1'b0;
      rst = 1'b0;
      repeat (10) cycle();
      chk("restart_first_accept", 32'(first_acc), 32'd0);
      chk("restart_latency", 32'(first_dec - first_acc), 32'd2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
